// File: rtl/demux2_stream.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// demux2_stream
// Registered 1-to-2 stream demultiplexer. One word per cycle is accepted on a
// valid/ready input and steered by S into a one-entry holding register for
// output 0 or output 1. Each output drains independently on its own
// valid/ready port, so a stalled output never blocks the other one.
//
// Ports
//   CLOCK           rising-edge clock
//   RESET           asynchronous active-low reset
//   S               destination select, sampled on accept
//   D[n-1:0]        input data word
//   VALID / READY   input handshake (READY is combinational)
//   Y0, VALID0      output 0 data / word present
//   READY0          output 0 downstream takes the word
//   Y1, VALID1      output 1 data / word present
//   READY1          output 1 downstream takes the word
//   COUNT0/COUNT1   words delivered per output, modulo 256
// ---------------------------------------------------------------------------
module demux2_stream #(
  parameter int n = 16
) (
  input  logic         CLOCK,
  input  logic         RESET,
  input  logic         S,
  input  logic [n-1:0] D,
  input  logic         VALID,
  output logic         READY,
  output logic [n-1:0] Y0,
  output logic         VALID0,
  input  logic         READY0,
  output logic [n-1:0] Y1,
  output logic         VALID1,
  input  logic         READY1,
  output logic [7:0]   COUNT0,
  output logic [7:0]   COUNT1
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  logic [1:0] w_valid;
  logic [1:0] w_out_ready;
  logic       w_sel_ready;
  logic       w_accept;

  assign w_out_ready = {READY1, READY0};

  // READY looks only at the output addressed by S. A FULL output can still
  // take a word when it drains in the same edge.
  assign w_sel_ready = S ? (!w_valid[1] | w_out_ready[1])
                         : (!w_valid[0] | w_out_ready[0]);
  assign READY       = RESET & w_sel_ready;
  assign w_accept    = VALID & READY;

  for (genvar gi = 0; gi < 2; gi++) begin : g_out
    state_t       r_state;
    logic [n-1:0] r_data;
    logic [7:0]   r_count;
    logic         w_fill;
    logic         w_drain;

    assign w_fill  = w_accept & (S == 1'(gi));
    assign w_drain = (r_state == ST_FULL) & w_out_ready[gi];

    always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
        r_state <= ST_EMPTY;
        r_data  <= '0;
        r_count <= '0;
      end else begin
        if (w_drain) begin
          r_count <= r_count + 8'd1;
        end
        case (r_state)
          ST_EMPTY: begin
            if (w_fill) begin
              r_data  <= D;
              r_state <= ST_FULL;
            end
          end
          ST_FULL: begin
            // A fill while FULL only happens together with a drain, so the
            // register is simply reloaded and stays FULL.
            if (w_fill) begin
              r_data <= D;
            end else if (w_drain) begin
              r_state <= ST_EMPTY;
            end
          end
          default: r_state <= ST_EMPTY;
        endcase
      end
    end
  end

  assign w_valid[0] = (g_out[0].r_state == ST_FULL);
  assign w_valid[1] = (g_out[1].r_state == ST_FULL);

  assign VALID0 = w_valid[0];
  assign VALID1 = w_valid[1];
  assign Y0     = g_out[0].r_data;
  assign Y1     = g_out[1].r_data;
  assign COUNT0 = g_out[0].r_count;
  assign COUNT1 = g_out[1].r_count;

endmodule

// File: tb/tb_demux2_stream.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_demux2_stream
// Self-checking bench for demux2_stream. A scoreboard queue per output is
// filled when an input word is accepted and popped when that output drains;
// directed checks cover reset, steering, back-pressure, streaming, hold
// stability and counter wrap.
// ---------------------------------------------------------------------------
module tb_demux2_stream;

  logic        CLOCK;
  logic        RESET;
  logic        S;
  logic [15:0] D;
  logic        VALID;
  logic        READY;
  logic [15:0] Y0;
  logic        VALID0;
  logic        READY0;
  logic [15:0] Y1;
  logic        VALID1;
  logic        READY1;
  logic [7:0]  COUNT0;
  logic [7:0]  COUNT1;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [7:0]  cnt_exp0 = 8'd0;
  logic [7:0]  cnt_exp1 = 8'd0;
  int          w;

  demux2_stream #(.n(16)) dut (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .S      (S),
    .D      (D),
    .VALID  (VALID),
    .READY  (READY),
    .Y0     (Y0),
    .VALID0 (VALID0),
    .READY0 (READY0),
    .Y1     (Y1),
    .VALID1 (VALID1),
    .READY1 (READY1),
    .COUNT0 (COUNT0),
    .COUNT1 (COUNT1)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: inputs only change just after a rising edge, so at the
  // falling edge the handshakes seen are the ones the next rising edge takes.
  always @(negedge CLOCK) begin
    if (RESET) begin
      check("count0", {24'd0, COUNT0}, {24'd0, cnt_exp0});
      check("count1", {24'd0, COUNT1}, {24'd0, cnt_exp1});
      if (VALID0 && READY0) begin
        if (q0.size() == 0) check("drain0_unexpected", 32'd1, 32'd0);
        else check("y0_drain", {16'd0, Y0}, {16'd0, q0.pop_front()});
        cnt_exp0 = cnt_exp0 + 8'd1;
      end
      if (VALID1 && READY1) begin
        if (q1.size() == 0) check("drain1_unexpected", 32'd1, 32'd0);
        else check("y1_drain", {16'd0, Y1}, {16'd0, q1.pop_front()});
        cnt_exp1 = cnt_exp1 + 8'd1;
      end
      if (VALID && READY) begin
        if (S) q1.push_back(D);
        else   q0.push_back(D);
      end
    end
  end

  task automatic clear_model();
    q0.delete();
    q1.delete();
    cnt_exp0 = 8'd0;
    cnt_exp1 = 8'd0;
  endtask

  task automatic idle();
    VALID = 1'b0;
    S     = 1'b0;
    D     = 16'h0000;
  endtask

  // Called just after a rising edge; returns just after the accepting edge
  // with VALID still high so back-to-back calls stream without bubbles.
  task automatic send(input logic s, input logic [15:0] d, output int waits);
    S = s; D = d; VALID = 1'b1; waits = 0;
    #1;
    while (!READY && waits < 20) begin
      @(posedge CLOCK); #2;
      waits++;
    end
    if (!READY) begin
      check("send_timeout", 32'd0, 32'd1);
      VALID = 1'b0;
    end else begin
      @(posedge CLOCK); #1;
    end
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    idle();
    READY0 = 1'b0;
    READY1 = 1'b0;
    clear_model();
    repeat (2) @(posedge CLOCK);
    #1 RESET = 1'b1;
    #1 check("ready_after_reset", {31'd0, READY}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b0; READY0 = 1'b0; READY1 = 1'b0;
    idle();
    // Reset state
    #2;
    check("rst_valid0", {31'd0, VALID0}, 32'd0);
    check("rst_valid1", {31'd0, VALID1}, 32'd0);
    check("rst_y0", {16'd0, Y0}, 32'd0);
    check("rst_y1", {16'd0, Y1}, 32'd0);
    check("rst_ready", {31'd0, READY}, 32'd0);
    @(posedge CLOCK); #1 RESET = 1'b1;
    #1 check("ready_after_release", {31'd0, READY}, 32'd1);

    // Basic steering
    READY0 = 1'b1; READY1 = 1'b1;
    send(1'b0, 16'h8000, w);
    check("steer_valid0", {31'd0, VALID0}, 32'd1);
    check("steer_y0", {16'd0, Y0}, 32'h8000);
    send(1'b1, 16'h0001, w);
    check("steer_valid1", {31'd0, VALID1}, 32'd1);
    check("steer_y1", {16'd0, Y1}, 32'h0001);
    check("steer_valid0_gone", {31'd0, VALID0}, 32'd0);
    idle();
    @(posedge CLOCK); #1;
    check("steer_valid1_gone", {31'd0, VALID1}, 32'd0);
    check("steer_count0", {24'd0, COUNT0}, 32'd1);
    check("steer_count1", {24'd0, COUNT1}, 32'd1);

    // Asynchronous reset with both outputs FULL
    READY0 = 1'b0; READY1 = 1'b0;
    send(1'b0, 16'haaaa, w);
    send(1'b1, 16'hbbbb, w);
    idle();
    check("full_valid0", {31'd0, VALID0}, 32'd1);
    check("full_valid1", {31'd0, VALID1}, 32'd1);
    #1 RESET = 1'b0;
    clear_model();
    #1;
    check("arst_valid0", {31'd0, VALID0}, 32'd0);
    check("arst_valid1", {31'd0, VALID1}, 32'd0);
    check("arst_y0", {16'd0, Y0}, 32'd0);
    check("arst_y1", {16'd0, Y1}, 32'd0);
    check("arst_count0", {24'd0, COUNT0}, 32'd0);
    check("arst_count1", {24'd0, COUNT1}, 32'd0);
    check("arst_ready", {31'd0, READY}, 32'd0);
    @(posedge CLOCK); #1 RESET = 1'b1;
    #1 check("arst_ready_release", {31'd0, READY}, 32'd1);

    // Back-pressure isolation
    do_reset();
    READY0 = 1'b0; READY1 = 1'b1;
    send(1'b0, 16'h234f, w);
    idle();
    check("bp_valid0", {31'd0, VALID0}, 32'd1);
    check("bp_y0", {16'd0, Y0}, 32'h234f);
    S = 1'b0; VALID = 1'b1;
    #1 check("bp_ready_s0", {31'd0, READY}, 32'd0);
    S = 1'b1;
    #1 check("bp_ready_s1", {31'd0, READY}, 32'd1);
    idle();
    send(1'b1, 16'hfeac, w);
    check("bp_wait_a", w, 32'd0);
    check("bp_y1_a", {16'd0, Y1}, 32'hfeac);
    send(1'b1, 16'h0101, w);
    check("bp_wait_b", w, 32'd0);
    check("bp_y1_b", {16'd0, Y1}, 32'h0101);
    check("bp_count1_a", {24'd0, COUNT1}, 32'd1);
    idle();
    @(posedge CLOCK); #1;
    check("bp_count1_b", {24'd0, COUNT1}, 32'd2);
    check("bp_hold_y0", {16'd0, Y0}, 32'h234f);
    check("bp_hold_valid0", {31'd0, VALID0}, 32'd1);
    check("bp_count0_stall", {24'd0, COUNT0}, 32'd0);
    READY0 = 1'b1;
    @(posedge CLOCK); #1;
    READY0 = 1'b0;
    check("bp_valid0_drained", {31'd0, VALID0}, 32'd0);
    check("bp_count0_once", {24'd0, COUNT0}, 32'd1);
    repeat (3) @(posedge CLOCK);
    #1 check("bp_count0_stays", {24'd0, COUNT0}, 32'd1);

    // Simultaneous drain and fill: 16 words, one per cycle
    do_reset();
    READY1 = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      send(1'b1, 16'(i), w);
      check("stream_wait", w, 32'd0);
      check("stream_y1", {16'd0, Y1}, i);
      check("stream_valid1", {31'd0, VALID1}, 32'd1);
    end
    idle();
    @(posedge CLOCK); #1;
    check("stream_count1", {24'd0, COUNT1}, 32'd16);
    check("stream_valid1_end", {31'd0, VALID1}, 32'd0);

    // Hold stability under back-pressure while D toggles
    do_reset();
    send(1'b0, 16'h3456, w);
    S = 1'b0; VALID = 1'b1;
    for (int k = 0; k < 5; k++) begin
      D = 16'($urandom);
      @(posedge CLOCK); #1;
      check("hold_y0", {16'd0, Y0}, 32'h3456);
      check("hold_valid0", {31'd0, VALID0}, 32'd1);
    end
    idle();
    READY0 = 1'b1;
    @(posedge CLOCK); #1;
    READY0 = 1'b0;
    check("hold_drained", {31'd0, VALID0}, 32'd0);
    check("hold_count0", {24'd0, COUNT0}, 32'd1);

    // Counter wrap on output 0
    do_reset();
    READY0 = 1'b1; READY1 = 1'b1;
    for (int j = 0; j < 256; j++) begin
      send(1'b0, 16'(j), w);
      if (j == 255) check("wrap_count0_ff", {24'd0, COUNT0}, 32'hff);
    end
    idle();
    @(posedge CLOCK); #1;
    check("wrap_count0_00", {24'd0, COUNT0}, 32'h00);
    check("wrap_count1", {24'd0, COUNT1}, 32'h00);

    @(posedge CLOCK); #1;
    check("sb_q0_empty", q0.size(), 32'd0);
    check("sb_q1_empty", q1.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
